result_display: RTL

Downstream presentation stage for the matrix multiplier. Accepts 16-bit result elements over a valid/ready handshake and buffers them in a small FIFO. Shows each element for a fixed dwell time on the four 7-segment digits (`hexDisplays`), then shows an end-of-matrix marker. Slide switch `sw0` freezes the sequence so a user can read the board.

---
 rtl/matrix_pkg.sv | 39 +++
 rtl/result_fifo.sv | 50 +++++
 rtl/result_display.sv | 118 +++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types, constants and 7-segment decode for the matrix multiplier result path.
package matrix_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, END} disp_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } res_elem_t;

  // Active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp always dark here.
  function automatic logic [7:0] hex_to_seg(logic [3:0] nib);
    logic [7:0] seg;
    unique case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO with registered occupancy count; DEPTH must be a power of two.
module result_fifo
  import matrix_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type elem_t = res_elem_t,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  elem_t         wdata,
  input  logic          pop,
  output elem_t         rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  elem_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/result_display.sv
// Buffers result elements and shows each on four 7-segment digits for DWELL cycles,
// followed by a dash marker after the last element of a matrix.
module result_display
  import matrix_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic            clk,
  input  logic            but0,
  input  logic            res_valid,
  input  logic [15:0]     res_data,
  input  logic            res_last,
  output logic            res_ready,
  input  logic            sw0,
  output logic [3:0][7:0] hexDisplays,
  output logic            busy
);

  localparam int unsigned DW = $clog2(DWELL);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  disp_state_t   state_q, state_d;
  res_elem_t     cur_q, cur_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          pop;
  res_elem_t     fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign res_ready = !fifo_full;

  result_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (res_elem_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (but0),
    .push  (res_valid && res_ready),
    .wdata (res_elem_t'{last: res_last, data: res_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          dwell_d = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (!sw0) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (cur_q.last)       state_d = END;
            else if (!fifo_empty) pop = 1'b1;
            else                  state_d = IDLE;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      END: begin
        if (!sw0) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            state_d = IDLE;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cur_d = pop ? fifo_rdata : cur_q;

  always_ff @(posedge clk or negedge but0) begin
    if (!but0) begin
      state_q <= IDLE;
      cur_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    hexDisplays = {4{SEG_BLANK}};
    case (state_q)
      SHOW: begin
        for (int i = 0; i < 4; i++) begin
          hexDisplays[i] = hex_to_seg(cur_q.data[4*i +: 4]);
        end
        // Decimal point on the rightmost digit flags the final element.
        if (cur_q.last) hexDisplays[0][7] = 1'b0;
      end
      END:     hexDisplays = {4{SEG_DASH}};
      default: hexDisplays = {4{SEG_BLANK}};
    endcase
  end

  assign busy = (state_q != IDLE) || (fifo_count != '0);

endmodule
